// File: rtl/tx_dma_pkg.sv
//------------------------------------------------------------------------------
// Module  : tx_dma_pkg
// Brief   : Shared types and constants for the TX DDR ring writer.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package tx_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_AW    = 3'd2,
        ST_W     = 3'd3,
        ST_B     = 3'd4,
        ST_CHECK = 3'd5
    } wr_state_e;

    localparam int BYTES_PER_BEAT = 16;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    function automatic logic [31:0] burst_bytes(input logic [8:0] len);
        burst_bytes = 32'(len) * 32'(BYTES_PER_BEAT);
    endfunction

    // Advance one burst around the ring, folding back to base at the end.
    function automatic logic [47:0] next_ring_addr(input logic [47:0] cur,
                                                   input logic [47:0] base,
                                                   input logic [31:0] size,
                                                   input logic [8:0]  len);
        logic [47:0] nxt;
        nxt = cur + 48'(burst_bytes(len));
        if ((nxt - base) >= 48'(size)) begin
            next_ring_addr = base;
        end else begin
            next_ring_addr = nxt;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_ddr_writer_if.sv
//------------------------------------------------------------------------------
// Module  : tx_ddr_writer_if
// Brief   : Sample stream in, AXI write (AW/W/B) out for the DDR ring writer.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tx_ddr_writer_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;

    logic [47:0]       m_axi_awaddr;
    logic [7:0]        m_axi_awlen;
    logic              m_axi_awvalid;
    logic              m_axi_awready;

    logic [DATA_W-1:0] m_axi_wdata;
    logic              m_axi_wlast;
    logic              m_axi_wvalid;
    logic              m_axi_wready;

    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;

    modport master (
        input  s_axis_tdata, s_axis_tvalid,
        output s_axis_tready,
        output m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );

endinterface

`default_nettype wire

// File: rtl/tx_stage_fifo.sv
//------------------------------------------------------------------------------
// Module  : tx_stage_fifo
// Brief   : Synchronous first-word-fall-through staging FIFO with occupancy.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tx_stage_fifo #(
    parameter  int DATA_W = 128,
    parameter  int DEPTH  = 512,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              push_i,
    input  wire logic [DATA_W-1:0] push_data_i,
    input  wire logic              pop_i,
    output logic      [DATA_W-1:0] head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic      [CNT_W-1:0]  count_o
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot the same cycle, so a push at full is still safe.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/tx_ddr_writer.sv
//------------------------------------------------------------------------------
// Module  : tx_ddr_writer
// Brief   : Stages a sample stream and writes it as AXI bursts into a DDR ring,
//           issuing four-phase occupancy credits. TX_DDR_WRITER_DEBUG_EN adds
//           debug mirror outputs.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tx_ddr_writer
    import tx_dma_pkg::*;
#(
    parameter int DATA_W      = 128,
    parameter int STAGE_DEPTH = 512
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        write_enable,
    input  wire logic [47:0] write_base_address,
    input  wire logic [31:0] write_ddr_size,
    input  wire logic [8:0]  write_burst_len,
    input  wire logic [16:0] write_access_size_bytes,
    input  wire logic        write_ddr_full,
    output logic             write_access_tick,
    input  wire logic        write_access_tick_ack,
    output logic             write_busy,
    output logic [2:0]       write_state,
    output logic [7:0]       write_error_count,
    output logic [31:0]      write_total_burst_count,
    tx_ddr_writer_if.master  bus
`ifdef TX_DDR_WRITER_DEBUG_EN
    ,
    output logic [47:0]      debug_awaddr,
    output logic             debug_wvalid,
    output logic             debug_wready,
    output logic [15:0]      debug_stage_count
`endif
);
    localparam int CNT_W = $clog2(STAGE_DEPTH) + 1;

    wr_state_e   state_q, state_d;
    logic [47:0] awaddr_q, awaddr_d;
    logic [8:0]  beat_q, beat_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [31:0] burst_cnt_q, burst_cnt_d;
    logic [31:0] credit_q, credit_d;
    logic        tick_q, tick_d;
    logic [31:0] credit_add;
    logic [31:0] credit_sub;

    logic              stage_full;
    logic              stage_empty;
    logic [CNT_W-1:0]  stage_count;
    logic [DATA_W-1:0] stage_head;
    logic              push;
    logic              pop;
    logic              wlast;

    tx_stage_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (STAGE_DEPTH)
    ) u_stage_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (bus.s_axis_tdata),
        .pop_i       (pop),
        .head_o      (stage_head),
        .full_o      (stage_full),
        .empty_o     (stage_empty),
        .count_o     (stage_count)
    );

    // Ready is held low through reset so no beat is lost into a flushing FIFO.
    assign bus.s_axis_tready = rst_n && write_enable && !stage_full;
    assign push              = bus.s_axis_tvalid && bus.s_axis_tready;

    assign bus.m_axi_awaddr  = awaddr_q;
    assign bus.m_axi_awlen   = 8'(write_burst_len - 9'd1);
    assign bus.m_axi_awvalid = (state_q == ST_AW);
    assign bus.m_axi_wdata   = stage_head;
    assign bus.m_axi_wvalid  = (state_q == ST_W) && !stage_empty;
    assign wlast             = (state_q == ST_W) && (beat_q == write_burst_len - 9'd1);
    assign bus.m_axi_wlast   = wlast;
    assign bus.m_axi_bready  = (state_q == ST_B);
    assign pop               = bus.m_axi_wvalid && bus.m_axi_wready;

    assign write_busy              = (state_q != ST_IDLE);
    assign write_state             = state_q;
    assign write_error_count       = err_cnt_q;
    assign write_total_burst_count = burst_cnt_q;
    assign write_access_tick       = tick_q;

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        beat_d      = beat_q;
        bresp_d     = bresp_q;
        err_cnt_d   = err_cnt_q;
        burst_cnt_d = burst_cnt_q;
        tick_d      = tick_q;
        credit_add  = '0;
        credit_sub  = '0;

        case (state_q)
            ST_IDLE: begin
                awaddr_d = write_base_address;
                if (write_enable) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!write_enable) begin
                    state_d = ST_IDLE;
                end else if ((32'(stage_count) >= 32'(write_burst_len)) && !write_ddr_full) begin
                    state_d = ST_AW;
                end
            end
            ST_AW: begin
                if (bus.m_axi_awready) begin
                    beat_d  = '0;
                    state_d = ST_W;
                end
            end
            ST_W: begin
                if (pop) begin
                    beat_d = beat_q + 9'd1;
                    if (wlast) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                if (bus.m_axi_bvalid) begin
                    bresp_d = bus.m_axi_bresp;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                awaddr_d = next_ring_addr(awaddr_q, write_base_address,
                                          write_ddr_size, write_burst_len);
                if ((bresp_q == SLVERR) || (bresp_q == DECERR)) begin
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    burst_cnt_d = burst_cnt_q + 32'd1;
                    credit_add  = burst_bytes(write_burst_len);
                end
                state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase

        // Four-phase credit handshake; a new tick waits for ack to fall.
        if (tick_q && write_access_tick_ack) begin
            tick_d = 1'b0;
        end else if (!tick_q && !write_access_tick_ack &&
                     (credit_q >= 32'(write_access_size_bytes))) begin
            tick_d     = 1'b1;
            credit_sub = 32'(write_access_size_bytes);
        end
        credit_d = credit_q + credit_add - credit_sub;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            awaddr_q    <= write_base_address;
            beat_q      <= '0;
            bresp_q     <= OKAY;
            err_cnt_q   <= '0;
            burst_cnt_q <= '0;
            credit_q    <= '0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            beat_q      <= beat_d;
            bresp_q     <= bresp_d;
            err_cnt_q   <= err_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            credit_q    <= credit_d;
            tick_q      <= tick_d;
        end
    end

`ifdef TX_DDR_WRITER_DEBUG_EN
    assign debug_awaddr      = awaddr_q;
    assign debug_wvalid      = bus.m_axi_wvalid;
    assign debug_wready      = bus.m_axi_wready;
    assign debug_stage_count = 16'(stage_count);
`endif

endmodule

`default_nettype wire

// File: tb/tb_tx_ddr_writer.sv
//------------------------------------------------------------------------------
// Module  : tb_tx_ddr_writer
// Brief   : Directed scoreboard bench for the DDR ring writer.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tx_ddr_writer;
    import tx_dma_pkg::*;

    localparam int DW    = 128;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_enable = 1'b0;
    logic [47:0] write_base_address = '0;
    logic [31:0] write_ddr_size = '0;
    logic [8:0]  write_burst_len = 9'd16;
    logic [16:0] write_access_size_bytes = '0;
    logic        write_ddr_full = 1'b0;
    logic        write_access_tick;
    logic        write_access_tick_ack = 1'b0;
    logic        write_busy;
    logic [2:0]  write_state;
    logic [7:0]  write_error_count;
    logic [31:0] write_total_burst_count;
`ifdef TX_DDR_WRITER_DEBUG_EN
    logic [47:0] debug_awaddr;
    logic        debug_wvalid;
    logic        debug_wready;
    logic [15:0] debug_stage_count;
`endif

    always #5 clk = ~clk;

    tx_ddr_writer_if #(.DATA_W(DW)) bus ();

    tx_ddr_writer #(
        .DATA_W      (DW),
        .STAGE_DEPTH (DEPTH)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .write_enable            (write_enable),
        .write_base_address      (write_base_address),
        .write_ddr_size          (write_ddr_size),
        .write_burst_len         (write_burst_len),
        .write_access_size_bytes (write_access_size_bytes),
        .write_ddr_full          (write_ddr_full),
        .write_access_tick       (write_access_tick),
        .write_access_tick_ack   (write_access_tick_ack),
        .write_busy              (write_busy),
        .write_state             (write_state),
        .write_error_count       (write_error_count),
        .write_total_burst_count (write_total_burst_count),
        .bus                     (bus)
`ifdef TX_DDR_WRITER_DEBUG_EN
        ,
        .debug_awaddr            (debug_awaddr),
        .debug_wvalid            (debug_wvalid),
        .debug_wready            (debug_wready),
        .debug_stage_count       (debug_stage_count)
`endif
    );

    typedef struct {
        logic [47:0] addr;
        logic [7:0]  len;
    } aw_t;
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } w_t;

    aw_t exp_aw[$];
    w_t  exp_w[$];
    int  checks = 0;
    int  errors = 0;
    int  w_seen = 0;
    int  b_idx = 0;
    int  err_burst = -1;
    int  tick_rises = 0;
    logic tick_prev = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // AW monitor: each address handshake consumes one expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.m_axi_awvalid && bus.m_axi_awready) begin
                if (exp_aw.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL aw_unexpected: actual addr=%0h expected no burst", bus.m_axi_awaddr);
                end else begin
                    aw_t e;
                    e = exp_aw.pop_front();
                    chk("awaddr", bus.m_axi_awaddr, e.addr);
                    chk("awlen", bus.m_axi_awlen, e.len);
                end
            end
        end
    end

    // W monitor: data order and wlast position.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.m_axi_wvalid && bus.m_axi_wready) begin
                w_seen++;
                if (exp_w.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w_unexpected: actual data=%0h expected no beat", bus.m_axi_wdata);
                end else begin
                    w_t e;
                    e = exp_w.pop_front();
                    chk("wdata", bus.m_axi_wdata, e.data);
                    chk("wlast", bus.m_axi_wlast, e.last);
                end
            end
        end
    end

    // B responder: one response per completed burst, error on burst err_burst.
    initial begin
        bus.m_axi_bvalid = 1'b0;
        bus.m_axi_bresp  = OKAY;
        forever begin
            @(negedge clk);
            if (rst_n && bus.m_axi_wvalid && bus.m_axi_wready && bus.m_axi_wlast) begin
                @(posedge clk);
                #1;
                bus.m_axi_bvalid = 1'b1;
                bus.m_axi_bresp  = (b_idx == err_burst) ? SLVERR : OKAY;
                b_idx++;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (bus.m_axi_bready) break;
                end
                @(posedge clk);
                #1;
                bus.m_axi_bvalid = 1'b0;
            end
        end
    end

    // Downstream reader: ack three cycles after a tick, drop after tick falls.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (write_access_tick && !write_access_tick_ack) begin
                repeat (3) @(posedge clk);
                #1;
                write_access_tick_ack = 1'b1;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (!write_access_tick) break;
                end
                @(posedge clk);
                #1;
                write_access_tick_ack = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (write_access_tick && !tick_prev) tick_rises++;
            if (!write_access_tick && tick_prev && rst_n)
                chk("tick_held_until_ack", write_access_tick_ack, 1'b1);
            tick_prev = write_access_tick;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic setup(input logic [47:0] b, input logic [31:0] sz, input logic [8:0] len,
                         input logic [16:0] acc, input int eb);
        write_enable            = 1'b0;
        write_ddr_full          = 1'b0;
        write_base_address      = b;
        write_ddr_size          = sz;
        write_burst_len         = len;
        write_access_size_bytes = acc;
        err_burst               = eb;
        rst_n                   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_aw.delete();
        exp_w.delete();
        b_idx      = 0;
        tick_rises = 0;
        w_seen     = 0;
    endtask

    task automatic stream(input int n, input int tag, input int len);
        for (int i = 0; i < n; i++) begin
            w_t e;
            int g;
            e.data = {32'(tag), 32'(i), 64'hC0FF_EE00_0000_0000 | 64'(i * 3)};
            e.last = ((i % len) == len - 1);
            exp_w.push_back(e);
            bus.s_axis_tdata  = e.data;
            bus.s_axis_tvalid = 1'b1;
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!bus.s_axis_tready && g < 200);
            if (!bus.s_axis_tready) chk("s_axis_ready_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic finish_test(input int nb);
        int g;
        for (g = 0; g < 3000; g++) begin
            @(negedge clk);
            if (write_total_burst_count + 32'(write_error_count) >= 32'(nb)) break;
        end
        chk("bursts_done_in_time", (g < 3000), 1'b1);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("idle_after_stop", write_state, 3'd0);
        chk("aw_all_seen", exp_aw.size(), 0);
        chk("w_all_seen", exp_w.size(), 0);
    endtask

    initial begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.m_axi_awready = 1'b1;
        bus.m_axi_wready  = 1'b1;

        // Reset state
        setup(48'h0000_0001_0000, 32'd4096, 9'd16, 17'd4096, -1);
        @(negedge clk);
        chk("rst_state", write_state, 3'd0);
        chk("rst_busy", write_busy, 1'b0);
        chk("rst_awvalid", bus.m_axi_awvalid, 1'b0);
        chk("rst_wvalid", bus.m_axi_wvalid, 1'b0);
        chk("rst_bready", bus.m_axi_bready, 1'b0);
        chk("rst_tick", write_access_tick, 1'b0);
        chk("rst_tready", bus.s_axis_tready, 1'b0);
        chk("rst_errcnt", write_error_count, 8'd0);
        chk("rst_burstcnt", write_total_burst_count, 32'd0);
        chk("rst_awaddr", bus.m_axi_awaddr, 48'h0000_0001_0000);

        // Four linear bursts of 16 beats
        setup(48'h0000_0001_0000, 32'd4096, 9'd16, 17'd4096, -1);
        exp_aw.push_back('{48'h0000_0001_0000, 8'd15});
        exp_aw.push_back('{48'h0000_0001_0100, 8'd15});
        exp_aw.push_back('{48'h0000_0001_0200, 8'd15});
        exp_aw.push_back('{48'h0000_0001_0300, 8'd15});
        write_enable = 1'b1;
        stream(64, 1, 16);
        finish_test(4);
        chk("t1_burst_count", write_total_burst_count, 32'd4);
        chk("t1_ticks", tick_rises, 0);

        // Ring wrap at 512 bytes
        setup(48'h0000_2000_0000, 32'd512, 9'd16, 17'd4096, -1);
        exp_aw.push_back('{48'h0000_2000_0000, 8'd15});
        exp_aw.push_back('{48'h0000_2000_0100, 8'd15});
        exp_aw.push_back('{48'h0000_2000_0000, 8'd15});
        write_enable = 1'b1;
        stream(48, 2, 16);
        finish_test(3);
        chk("t2_burst_count", write_total_burst_count, 32'd3);

        // Access ticks every 512 bytes
        setup(48'h0000_0003_0000, 32'd4096, 9'd16, 17'd512, -1);
        exp_aw.push_back('{48'h0000_0003_0000, 8'd15});
        exp_aw.push_back('{48'h0000_0003_0100, 8'd15});
        exp_aw.push_back('{48'h0000_0003_0200, 8'd15});
        exp_aw.push_back('{48'h0000_0003_0300, 8'd15});
        write_enable = 1'b1;
        stream(64, 3, 16);
        finish_test(4);
        chk("t3_ticks", tick_rises, 2);
        chk("t3_tick_low_at_end", write_access_tick, 1'b0);

        // SLVERR on the second burst
        setup(48'h0000_0004_0000, 32'd4096, 9'd16, 17'd256, 1);
        exp_aw.push_back('{48'h0000_0004_0000, 8'd15});
        exp_aw.push_back('{48'h0000_0004_0100, 8'd15});
        exp_aw.push_back('{48'h0000_0004_0200, 8'd15});
        exp_aw.push_back('{48'h0000_0004_0300, 8'd15});
        write_enable = 1'b1;
        stream(64, 4, 16);
        finish_test(4);
        chk("t4_err_count", write_error_count, 8'd1);
        chk("t4_burst_count", write_total_burst_count, 32'd3);
        chk("t4_ticks", tick_rises, 3);

        // DDR full holds off bursts
        setup(48'h0000_0005_0000, 32'd4096, 9'd16, 17'd4096, -1);
        write_ddr_full = 1'b1;
        write_enable   = 1'b1;
        exp_aw.push_back('{48'h0000_0005_0000, 8'd15});
        exp_aw.push_back('{48'h0000_0005_0100, 8'd15});
        stream(32, 5, 16);
        begin
            int aw_cycles;
            int lat;
            aw_cycles = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.m_axi_awvalid) aw_cycles++;
            end
            chk("t5_awvalid_while_full", aw_cycles, 0);
            chk("t5_state_wait", write_state, 3'd1);
            @(posedge clk);
            #1;
            write_ddr_full = 1'b0;
            lat = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
                if (bus.m_axi_awvalid) break;
            end
            chk("t5_aw_within_2", (lat <= 2), 1'b1);
        end
        finish_test(2);

        // Reset during W beat 7
        setup(48'h0000_0006_0000, 32'd4096, 9'd16, 17'd4096, -1);
        write_ddr_full = 1'b1;
        write_enable   = 1'b1;
        exp_aw.push_back('{48'h0000_0006_0000, 8'd15});
        stream(32, 6, 16);
        write_ddr_full = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (w_seen >= 7) break;
        end
        chk("t6_reached_beat7", (w_seen >= 7), 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_tready_in_reset", bus.s_axis_tready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("t6_awvalid", bus.m_axi_awvalid, 1'b0);
        chk("t6_wvalid", bus.m_axi_wvalid, 1'b0);
        chk("t6_bready", bus.m_axi_bready, 1'b0);
        chk("t6_state", write_state, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_aw.delete();
        exp_w.delete();
        begin
            int aw_cycles;
            aw_cycles = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (bus.m_axi_awvalid) aw_cycles++;
            end
            chk("t6_fifo_flushed_no_aw", aw_cycles, 0);
            chk("t6_state_wait_after", write_state, 3'd1);
        end
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
